// File: rtl/opb_register_bank_ppc2simulink.sv
// OPB slave register bank: C_N_REGS PPC-writable control registers followed by
// C_N_STATUS read-only status words in one address window. Control registers
// drive the Simulink fabric with data plus a one-cycle write strobe; registers
// flagged in C_AUTOCLR fall back to C_RST_VAL after one cycle (command pulses).
module opb_register_bank_ppc2simulink #(
    parameter logic [31:0] C_BASEADDR   = 32'h01001100,
    parameter logic [31:0] C_HIGHADDR   = 32'h010011FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter int          C_N_REGS     = 4,
    parameter int          C_N_STATUS   = 2,
    parameter logic [31:0] C_RST_VAL    = 32'h00000000,
    parameter logic [15:0] C_AUTOCLR    = 16'h0000,
    parameter              C_FAMILY     = "virtex5"
) (
    input  logic                        OPB_Clk,
    input  logic                        OPB_Rst,
    input  logic [0:C_OPB_AWIDTH-1]     OPB_ABus,
    input  logic [0:C_OPB_DWIDTH/8-1]   OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1]     OPB_DBus,
    input  logic                        OPB_RNW,
    input  logic                        OPB_select,
    input  logic                        OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1]     Sl_DBus,
    output logic                        Sl_xferAck,
    output logic                        Sl_errAck,
    output logic                        Sl_retry,
    output logic                        Sl_toutSup,
    output logic [32*C_N_REGS-1:0]      user_data_out,
    output logic [C_N_REGS-1:0]         user_wr_strobe,
    input  logic [32*C_N_STATUS-1:0]    user_data_in
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACK  = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    // Family only selects the target; it has no effect on the logic.
    localparam logic FAM_SET = |C_FAMILY;

    state_t        state_q, state_d;

    // Bus view with OPB bit 0 as MSB: a packed copy maps OPB bit 0 to bit 31.
    logic [31:0]   addr;
    logic [31:0]   wdata_in;
    logic [3:0]    be_in;
    logic [31:0]   offset;
    logic [29:0]   idx_d;
    logic          hit;
    logic [31:0]   rd_mux;

    // Transfer captured on the IDLE->ACK edge.
    logic [29:0]   idx_q;
    logic          rnw_q;
    logic [3:0]    be_q;
    logic [31:0]   wdata_q;
    logic [31:0]   rdata_q;

    logic [31:0]   regs_q [C_N_REGS];
    logic [C_N_REGS-1:0] strobe_q;

    logic          unused_ok;

    // Byte-lane merge: be[3] covers bits 31:24 (OPB byte lane 0).
    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  be);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

    assign addr     = OPB_ABus;
    assign wdata_in = OPB_DBus;
    assign be_in    = OPB_BE;
    assign offset   = addr - C_BASEADDR;
    assign idx_d    = offset[31:2];
    assign hit      = OPB_select && (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);

    // Read mux: control registers, then status words, otherwise zero.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < C_N_REGS; i++) begin
            if (idx_d == 30'(i)) rd_mux = regs_q[i];
        end
        for (int j = 0; j < C_N_STATUS; j++) begin
            if (idx_d == 30'(C_N_REGS + j)) rd_mux = user_data_in[32*j +: 32];
        end
    end

    // State register; reset aborts any transfer in flight.
    always_ff @(posedge OPB_Clk or negedge OPB_Rst) begin
        if (!OPB_Rst) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next state: one wait cycle, one ack cycle, one gap cycle that ignores select.
    always_comb begin
        state_d = S_IDLE;
        unique case (state_q)
            S_IDLE:  state_d = hit ? S_ACK : S_IDLE;
            S_ACK:   state_d = S_GAP;
            S_GAP:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs: ack and read data only during ACK.
    always_comb begin
        Sl_xferAck = (state_q == S_ACK);
        Sl_DBus    = (state_q == S_ACK) ? rdata_q : '0;
        Sl_errAck  = 1'b0;
        Sl_retry   = 1'b0;
        Sl_toutSup = 1'b0;
    end

    // Capture address, direction, byte enables, write data and read data on accept.
    always_ff @(posedge OPB_Clk) begin
        if (state_q == S_IDLE && hit) begin
            idx_q   <= idx_d;
            rnw_q   <= OPB_RNW;
            be_q    <= be_in;
            wdata_q <= wdata_in;
            rdata_q <= OPB_RNW ? rd_mux : '0;
        end
    end

    // Control registers: commit at end of ACK, strobe during GAP, auto-clear at end of GAP.
    always_ff @(posedge OPB_Clk or negedge OPB_Rst) begin
        if (!OPB_Rst) begin
            for (int i = 0; i < C_N_REGS; i++) regs_q[i] <= C_RST_VAL;
            strobe_q <= '0;
        end else begin
            strobe_q <= '0;
            for (int i = 0; i < C_N_REGS; i++) begin
                if (state_q == S_ACK && !rnw_q && idx_q == 30'(i)) begin
                    regs_q[i]   <= byte_merge(regs_q[i], wdata_q, be_q);
                    strobe_q[i] <= 1'b1;
                end else if (state_q == S_GAP && C_AUTOCLR[i]) begin
                    regs_q[i]   <= C_RST_VAL;
                end
            end
        end
    end

    for (genvar gi = 0; gi < C_N_REGS; gi++) begin : g_out
        assign user_data_out[32*gi +: 32] = regs_q[gi];
    end

    assign user_wr_strobe = strobe_q;

    assign unused_ok = &{1'b0, OPB_seqAddr, offset[1:0], FAM_SET};

endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// Randomised and directed bench for the OPB register bank, with a queue
// scoreboard drained by an independent monitor.
module tb_opb_register_bank_ppc2simulink;

    localparam int          N_REGS   = 4;
    localparam int          N_STATUS = 2;
    localparam logic [31:0] BASE     = 32'h01001100;
    localparam logic [31:0] HIGH     = 32'h010011FF;
    localparam logic [15:0] AUTOCLR  = 16'h0008;

    logic        clk;
    logic        rst_n;
    logic [0:31] abus;
    logic [0:3]  be;
    logic [0:31] dbus;
    logic        rnw;
    logic        sel;
    logic        seq;
    logic [0:31] sl_dbus;
    logic        ack, err_ack, retry, tout;
    logic [32*N_REGS-1:0]   data_out;
    logic [N_REGS-1:0]      strobe;
    logic [32*N_STATUS-1:0] data_in;

    logic [31:0] model  [N_REGS];
    logic [31:0] status [N_STATUS];

    typedef struct {
        bit           rnw;
        logic [31:0]  rdata;
        logic [3:0]   strobe;
        logic [127:0] out_gap;
        logic [127:0] out_after;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    opb_register_bank_ppc2simulink #(
        .C_BASEADDR(BASE), .C_HIGHADDR(HIGH), .C_OPB_AWIDTH(32), .C_OPB_DWIDTH(32),
        .C_N_REGS(N_REGS), .C_N_STATUS(N_STATUS), .C_RST_VAL(32'h0),
        .C_AUTOCLR(AUTOCLR), .C_FAMILY("virtex5")
    ) dut (
        .OPB_Clk(clk), .OPB_Rst(rst_n), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus),
        .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seq),
        .Sl_DBus(sl_dbus), .Sl_xferAck(ack), .Sl_errAck(err_ack), .Sl_retry(retry),
        .Sl_toutSup(tout), .user_data_out(data_out), .user_wr_strobe(strobe),
        .user_data_in(data_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign data_in = {status[1], status[0]};

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] pack_model();
        return {model[3], model[2], model[1], model[0]};
    endfunction

    // Expected response for one transfer, derived from the register map rules.
    function automatic exp_t predict(input logic [31:0] a, input bit rd,
                                     input logic [0:3] b, input logic [31:0] d);
        exp_t e;
        int   idx;
        idx      = int'((a - BASE) / 4);
        e.rnw    = rd;
        e.rdata  = '0;
        e.strobe = '0;
        if (rd) begin
            if (idx < N_REGS)                 e.rdata = model[idx];
            else if (idx < N_REGS + N_STATUS) e.rdata = status[idx - N_REGS];
        end else if (idx < N_REGS) begin
            for (int k = 0; k < 4; k++)
                if (b[k]) model[idx][31-8*k -: 8] = d[31-8*k -: 8];
            e.strobe[idx] = 1'b1;
        end
        e.out_gap = pack_model();
        for (int i = 0; i < N_REGS; i++) if (AUTOCLR[i]) model[i] = 32'h0;
        e.out_after = pack_model();
        return e;
    endfunction

    // One transfer starting on a negedge with the slave idle; returns on a negedge with it idle again.
    task automatic xfer(input logic [31:0] a, input bit rd, input logic [0:3] b, input logic [31:0] d);
        int lat;
        bit got;
        sb.push_back(predict(a, rd, b, d));
        abus = a; rnw = rd; be = b; dbus = d; sel = 1'b1;
        lat = 0; got = 1'b0;
        while (!got && lat < 8) begin
            @(posedge clk); #1;
            lat++;
            got = ack;
        end
        chk("ack_latency", 128'(lat), 128'd1);
        sel = 1'b0; rnw = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    // Monitor: pops the scoreboard on every ack and checks the following cycles.
    bit   pend, pend2, prev_ack;
    exp_t cur;
    always @(negedge clk) begin
        if (!rst_n) begin
            pend = 0; pend2 = 0; prev_ack = 0;
        end else begin
            if (pend2) begin
                chk("settled_out", data_out, cur.out_after);
                pend2 = 0;
            end
            if (pend) begin
                chk("gap_strobe", 128'(strobe), 128'(cur.strobe));
                chk("gap_out", data_out, cur.out_gap);
                pend = 0; pend2 = 1;
            end else begin
                chk("strobe_idle", 128'(strobe), 128'd0);
            end
            if (ack) begin
                chk("ack_not_consecutive", 128'(prev_ack), 128'd0);
                if (sb.size() == 0) begin
                    chk("unexpected_ack", 128'd1, 128'd0);
                end else begin
                    cur = sb.pop_front();
                    if (cur.rnw) chk("read_data", 128'(sl_dbus), 128'(cur.rdata));
                    pend = 1;
                end
            end else begin
                chk("dbus_zero_outside_ack", 128'(sl_dbus), 128'd0);
            end
            prev_ack = ack;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        rst_n = 1'b0; sel = 1'b0; rnw = 1'b1; be = 4'b0; dbus = '0; abus = '0; seq = 1'b0;
        for (int i = 0; i < N_REGS; i++) model[i] = 32'h0;
        status[0] = 32'h0; status[1] = 32'h0;
        repeat (2) @(negedge clk);
        chk("reset_ack", 128'(ack), 128'd0);
        chk("reset_dbus", 128'(sl_dbus), 128'd0);
        chk("reset_out", data_out, 128'd0);
        chk("reset_strobe", 128'(strobe), 128'd0);
        chk("tied_zero", 128'({err_ack, retry, tout}), 128'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset asserted while the ack is on the bus: abort, no write, no strobe.
        abus = BASE; rnw = 1'b0; be = 4'b1111; dbus = 32'h12345678; sel = 1'b1;
        @(posedge clk); #1;
        chk("ack_before_reset", 128'(ack), 128'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_ack_reset_ack", 128'(ack), 128'd0);
        chk("mid_ack_reset_out", data_out, 128'd0);
        chk("mid_ack_reset_strobe", 128'(strobe), 128'd0);
        sel = 1'b0; rnw = 1'b1;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        xfer(BASE, 1'b1, 4'b1111, 32'h0);

        // Full word write and readback.
        xfer(32'h01001104, 1'b0, 4'b1111, 32'hDEADBEEF);
        xfer(32'h01001104, 1'b1, 4'b1111, 32'h0);

        // Partial byte-lane write.
        xfer(32'h01001100, 1'b0, 4'b1111, 32'h11223344);
        xfer(32'h01001100, 1'b0, 4'b0101, 32'hAABBCCDD);
        chk("partial_reg0", 128'(data_out[31:0]), 128'h11BB33DD);
        xfer(32'h01001100, 1'b1, 4'b1111, 32'h0);

        // Status words: readable, writes ignored.
        status[0] = 32'hCAFE0001; status[1] = 32'h0BADF00D;
        xfer(32'h01001110, 1'b1, 4'b1111, 32'h0);
        xfer(32'h01001110, 1'b0, 4'b1111, 32'h55555555);
        xfer(32'h01001117, 1'b1, 4'b1111, 32'h0);

        // Auto-clear register 3 and zero byte-enable write.
        xfer(32'h0100110C, 1'b0, 4'b1111, 32'h00000005);
        xfer(32'h0100110C, 1'b1, 4'b1111, 32'h0);
        xfer(32'h01001104, 1'b0, 4'b0000, 32'hFFFFFFFF);
        xfer(32'h01001104, 1'b1, 4'b1111, 32'h0);

        // Unmapped read with select held for 6 cycles: exactly two acks.
        sb.push_back(predict(32'h01001180, 1'b1, 4'b1111, 32'h0));
        sb.push_back(predict(32'h01001180, 1'b1, 4'b1111, 32'h0));
        abus = 32'h01001180; rnw = 1'b1; be = 4'b1111; sel = 1'b1;
        n = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (ack) n++;
        end
        @(negedge clk); sel = 1'b0;
        repeat (3) @(negedge clk);
        chk("held_select_acks", 128'(n), 128'd2);

        // Outside the window: never acknowledged.
        abus = 32'h01001200; sel = 1'b1; n = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (ack) n++;
        end
        @(negedge clk); sel = 1'b0;
        chk("out_of_window_acks", 128'(n), 128'd0);

        // Randomised traffic across controls, status and unmapped words.
        for (int t = 0; t < 60; t++) begin
            logic [31:0] a;
            if ($urandom_range(0, 3) == 0) begin
                status[0] = $urandom; status[1] = $urandom;
            end
            a = BASE + 32'($urandom_range(0, 9)) * 4 + 32'($urandom_range(0, 3));
            xfer(a, 1'($urandom_range(0, 1)), 4'($urandom), $urandom);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 128'(sb.size()), 128'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/opb_register_bank_ppc2simulink.md
Name: opb_register_bank_ppc2simulink

Overview:
Parametrised successor to the single software register: OPB slave holding C_N_REGS PPC-writable control registers plus C_N_STATUS read-only status words, all in one address window. Drives the Simulink user fabric with per-register data and one-cycle write strobes. Optional per-register auto-clear turns a control register into a command pulse. Sits on the ROACH OPB bus beside the existing software registers; everything runs on OPB_Clk.

Parameters:
C_BASEADDR, 32'h01001100, window base; register i at C_BASEADDR + 4*i
C_HIGHADDR, 32'h010011FF, window top; must cover 4*(C_N_REGS+C_N_STATUS) bytes
C_OPB_AWIDTH, 32, OPB address width (fixed 32)
C_OPB_DWIDTH, 32, OPB data width (fixed 32)
C_N_REGS, 4, RW control registers, 1..16
C_N_STATUS, 2, RO status words, 0..16
C_RST_VAL, 32'h00000000, reset/auto-clear value of every control register
C_AUTOCLR, 16'h0000, bit i=1: control register i auto-clears
C_FAMILY, "virtex5", target family

Ports:
OPB_Clk  in  1  single clock; OPB and user logic
OPB_Rst  in  1  asynchronous, active-low reset
OPB_ABus  in  [0:31]  address
OPB_BE  in  [0:3]  byte enables; BE[0] = DBus[0:7]
OPB_DBus  in  [0:31]  write data
OPB_RNW  in  1  1=read, 0=write
OPB_select  in  1  transfer request
OPB_seqAddr  in  1  ignored
Sl_DBus  out  [0:31]  read data, zero outside ACK
Sl_xferAck  out  1  transfer acknowledge
Sl_errAck, Sl_retry, Sl_toutSup  out  1 each  tied 0
user_data_out  out  [32*C_N_REGS-1:0]  reg i on [32i+31:32i]; OPB bit 0 = bit 31
user_wr_strobe  out  [C_N_REGS-1:0]  one-cycle pulse per register write
user_data_in  in  [32*C_N_STATUS-1:0]  status word j on [32j+31:32j]

Behaviour:
- Reset (OPB_Rst=0, async): state IDLE; control regs = C_RST_VAL; Sl_xferAck=0; Sl_DBus=0; user_wr_strobe=0. Asserted mid-transfer: transfer aborted, no ack, no strobe.
- Decode: hit = OPB_select & C_BASEADDR <= ABus <= C_HIGHADDR; idx = (ABus - C_BASEADDR) >> 2; ABus[30:31] ignored.
- FSM: IDLE -> ACK on hit; ACK -> GAP; GAP -> IDLE. Ack latency: xferAck high exactly the 2nd cycle of select (1-cycle wait), 1 cycle wide. GAP ignores select so a lingering select is never double-acked. Max 1 transfer / 3 cycles.
- IDLE->ACK edge: latch idx, RNW, BE, DBus; read mux captured into Sl_DBus register (status words sampled at this edge). Sl_DBus nonzero only in ACK.
- Read: idx<C_N_REGS -> control reg; C_N_REGS<=idx<C_N_REGS+C_N_STATUS -> status word; else 0. Still acked.
- Write: at end of ACK, control reg idx takes DBus per byte where BE=1; other bytes kept. Writes to status/unmapped idx: acked, no effect, no strobe. BE=0000 to a control reg: no data change, strobe still fires.
- user_wr_strobe[idx]=1 for the cycle after ACK (GAP), coincident with new value on user_data_out.
- Auto-clear: if C_AUTOCLR[i], reg i returns to C_RST_VAL at end of GAP: written value visible exactly one cycle, aligned with strobe. Readback of auto-clear reg returns C_RST_VAL except the GAP cycle.
- No user-side write path; user_data_out changes only by OPB write, auto-clear or reset.

Test Plan:
- Reset: OPB_Rst low mid-ACK -> xferAck=0 immediately, user_data_out all 0, strobes 0; FSM IDLE after release.
- Write 0xDEADBEEF to 0x01001104, BE=1111 -> xferAck on 2nd select cycle; next cycle user_wr_strobe=0010, user_data_out[63:32]=0xDEADBEEF; readback 0xDEADBEEF.
- Partial: reg0=0x11223344, write 0xAABBCCDD BE=0101 -> reg0=0x11BB33DD, strobe[0] one cycle.
- Status: user_data_in word0=0xCAFE0001, read 0x01001110 (idx 4, N_REGS=4) -> Sl_DBus=0xCAFE0001 in ACK only; write there -> ack, no strobe, no change.
- Auto-clear C_AUTOCLR=0x0008: write 0x5 to reg3 -> user_data_out[127:96]=0x5 one cycle with strobe[3], then 0x0.
- Unmapped 0x01001180 read -> ack, data 0; select held 6 cycles -> exactly one ack per IDLE->ACK->GAP cycle, never consecutive.
